alu_arbiter: RTL and testbench

Two-requester controller for the registered 8-bit ALU in the processor datapath. Accepts operation requests over valid/ready handshakes and arbitrates round-robin. It drives the ALU operand and control inputs, waits out the ALU's one-clock registered latency, and returns the result and zero status to the granted requester through a held response handshake. It also screens opcodes and counts completed operations.

---
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu_arbiter.sv | 72 +++++++
 tb/tb_alu_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, shared response and ALU-side signals for alu_arbiter
interface alu_arbiter_if #(parameter int CNT_W = 16);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_result;
  logic rsp_zero, rsp_err;
  logic [7:0] alu_d, alu_c, alu_acc;
  logic [3:0] alu_control;
  logic alu_status;
  logic busy;
  logic [CNT_W-1:0] ops_done;
  modport slave (
    input req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    input rsp0_ready, rsp1_ready, alu_acc, alu_status,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output alu_d, alu_c, alu_control, busy, ops_done
  );
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_acc, alu_status,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input alu_d, alu_c, alu_control, busy, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a registered 8-bit ALU with held responses
module alu_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  state_t state;
  logic last_grant, owner, err_q, grant, xfer, legal;
  logic [3:0] op;
  logic [7:0] a, b;
  always_comb begin
    grant = (bus.req0_valid & bus.req1_valid) ? (RR_EN ? ~last_grant : 1'b0) : bus.req1_valid;
    op = grant ? bus.req1_op : bus.req0_op;
    a = grant ? bus.req1_a : bus.req0_a;
    b = grant ? bus.req1_b : bus.req0_b;
    legal = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hC, 4'hD};
    bus.req0_ready = ~rst & (state == IDLE) & bus.req0_valid & ~grant;
    bus.req1_ready = ~rst & (state == IDLE) & bus.req1_valid & grant;
    xfer = bus.req0_ready | bus.req1_ready;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      err_q <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.alu_d <= '0;
      bus.alu_c <= '0;
      bus.alu_control <= '0;
      bus.ops_done <= '0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          bus.alu_d <= a;
          bus.alu_c <= b;
          bus.alu_control <= legal ? op : 4'h0;
          err_q <= ~legal;
          owner <= grant;
          last_grant <= grant;
          state <= EXEC;
        end
        EXEC: state <= CAPT;
        CAPT: begin
          // illegal ops report a forced zero result regardless of what the ALU produced
          bus.rsp_result <= err_q ? 8'h00 : bus.alu_acc;
          bus.rsp_zero <= err_q | bus.alu_status;
          bus.rsp_err <= err_q;
          bus.rsp0_valid <= ~owner;
          bus.rsp1_valid <= owner;
          state <= RESP;
        end
        RESP: if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
          bus.ops_done <= bus.ops_done + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  logic clk, rst;
  int checks = 0, failures = 0;
  logic mlast;
  int mops;
  logic [15:0] legal_mask = 16'b0011_1100_0000_1111;
  alu_arbiter_if #(.CNT_W(16)) m();
  alu_arbiter_if #(.CNT_W(2)) f();
  alu_arbiter #(.RR_EN(1'b1), .CNT_W(16)) dut_rr (.clk(clk), .rst(rst), .bus(m.slave));
  alu_arbiter #(.RR_EN(1'b0), .CNT_W(2)) dut_fp (.clk(clk), .rst(rst), .bus(f.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return ~(a | b);
      4'hA: return {7'd0, a != b};
      4'hB: return {7'd0, a < b};
      4'hC: return a << b[2:0];
      4'hD: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction
  // registered ALU models, deliberately unreset
  always @(posedge clk) begin
    m.alu_acc <= alu_f(m.alu_control, m.alu_d, m.alu_c);
    m.alu_status <= alu_f(m.alu_control, m.alu_d, m.alu_c) == 8'h00;
    f.alu_acc <= alu_f(f.alu_control, f.alu_d, f.alu_c);
    f.alu_status <= alu_f(f.alu_control, f.alu_d, f.alu_c) == 8'h00;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input int n, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (n == 0) begin m.req0_op = op; m.req0_a = a; m.req0_b = b; end
    else begin m.req1_op = op; m.req1_a = a; m.req1_b = b; end
  endtask
  task automatic run(input logic v0, input logic v1, input int hold);
    logic g, ee;
    logic [3:0] op;
    logic [7:0] a, b, er;
    @(posedge clk); #1;
    m.req0_valid = v0; m.req1_valid = v1; #1;
    g = (v0 && v1) ? !mlast : v1;
    for (int t = 0; t < 20 && !(m.req0_ready || m.req1_ready); t++) begin @(posedge clk); #2; end
    chk("req_ready", {m.req1_ready, m.req0_ready}, g ? 2 : 1);
    op = g ? m.req1_op : m.req0_op;
    a = g ? m.req1_a : m.req0_a;
    b = g ? m.req1_b : m.req0_b;
    ee = !legal_mask[op];
    er = ee ? 8'h00 : alu_f(op, a, b);
    @(posedge clk); #1;
    m.req0_valid = 1'b0; m.req1_valid = 1'b0; mlast = g;
    chk("alu_inputs", {m.alu_control, m.alu_d, m.alu_c}, {ee ? 4'h0 : op, a, b});
    @(negedge clk);
    chk("exec", {m.busy, m.req1_ready, m.req0_ready, m.rsp1_valid, m.rsp0_valid}, 5'b10000);
    @(negedge clk);
    chk("capt_novalid", {m.rsp1_valid, m.rsp0_valid}, 0);
    @(negedge clk);
    chk("rsp_valid", {m.rsp1_valid, m.rsp0_valid}, g ? 2 : 1);
    chk("rsp_fields", {m.rsp_result, m.rsp_zero, m.rsp_err}, {er, er == 8'h00, ee});
    for (int t = 0; t < hold; t++) begin
      @(negedge clk);
      chk("hold", {m.rsp1_valid, m.rsp0_valid, m.req1_ready, m.req0_ready, m.rsp_result, m.rsp_zero, m.rsp_err, m.ops_done},
          {g ? 2'b10 : 2'b01, 2'b00, er, er == 8'h00, ee, mops[15:0]});
    end
    if (g) m.rsp1_ready = 1'b1; else m.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    m.rsp0_ready = 1'b0; m.rsp1_ready = 1'b0; mops++;
    chk("consume", {m.rsp1_valid, m.rsp0_valid, m.busy, m.ops_done}, {3'b000, mops[15:0]});
  endtask
  initial begin
    logic v0, v1;
    logic [7:0] ea;
    m.req0_valid = 0; m.req1_valid = 0; m.rsp0_ready = 0; m.rsp1_ready = 0;
    f.req0_valid = 0; f.req1_valid = 0; f.rsp0_ready = 0; f.rsp1_ready = 0;
    req(0, 0, 0, 0); req(1, 0, 0, 0);
    f.req0_op = 0; f.req1_op = 0; f.req0_a = 0; f.req0_b = 0; f.req1_a = 0; f.req1_b = 0;
    rst = 1'b1; mlast = 1'b1; mops = 0;
    m.req0_valid = 1'b1;
    @(negedge clk);
    chk("reset_ctl", {m.req1_ready, m.req0_ready, m.rsp1_valid, m.rsp0_valid, m.rsp_zero, m.rsp_err, m.busy}, 0);
    chk("reset_data", {m.rsp_result, m.alu_d, m.alu_c, m.alu_control}, 0);
    chk("reset_cnt", m.ops_done, 0);
    m.req0_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    req(0, 4'h0, 8'h05, 8'h03); run(1, 0, 0);
    req(1, 4'h1, 8'h2A, 8'h2A); run(0, 1, 0);
    req(0, 4'hB, 8'h01, 8'h02); run(1, 0, 0);
    req(1, 4'h4, 8'hFF, 8'h01); run(0, 1, 0);
    req(0, 4'h2, 8'hF0, 8'h3C); run(1, 0, 5);
    // reset while the op is in EXEC
    req(0, 4'h0, 8'h11, 8'h22);
    @(posedge clk); #1; m.req0_valid = 1'b1;
    @(posedge clk); #1; m.req0_valid = 1'b0;
    @(negedge clk);
    chk("midop_busy", m.busy, 1);
    rst = 1'b1; #1;
    chk("midop_rst_ctl", {m.req1_ready, m.req0_ready, m.rsp1_valid, m.rsp0_valid, m.rsp_zero, m.rsp_err, m.busy}, 0);
    chk("midop_rst_data", {m.rsp_result, m.alu_d, m.alu_c, m.alu_control}, 0);
    chk("midop_rst_cnt", m.ops_done, 0);
    @(posedge clk); #1; rst = 1'b0; mops = 0; mlast = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("midop_quiet", {m.rsp1_valid, m.rsp0_valid, m.busy}, 0);
    end
    for (int k = 0; k < 4; k++) begin
      req(0, 4'h0, 8'($urandom), 8'($urandom));
      req(1, 4'h3, 8'($urandom), 8'($urandom));
      run(1, 1, 0);
      chk("rr_order", mlast, k % 2);
    end
    req(0, 4'hC, 8'h81, 8'h01); run(1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      req(0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      req(1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      run(v0, v1, $urandom_range(0, 2));
    end
    // fixed-priority instance with a 2-bit counter so the wrap is reachable
    @(posedge clk); #1;
    f.req0_a = 8'($urandom); f.req0_b = 8'($urandom); f.req1_a = 8'($urandom); f.req1_b = 8'($urandom);
    f.req0_valid = 1'b1; f.req1_valid = 1'b1; f.rsp0_ready = 1'b1; f.rsp1_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 20 && !(f.req0_ready || f.req1_ready); t++) begin @(posedge clk); #2; end
      chk("fp_grant", {f.req1_ready, f.req0_ready}, 1);
      ea = f.req0_a + f.req0_b;
      @(posedge clk); #1;
      f.req0_a = 8'($urandom); f.req0_b = 8'($urandom);
      for (int t = 0; t < 10 && !(f.rsp0_valid || f.rsp1_valid); t++) begin @(posedge clk); #2; end
      chk("fp_rsp", {f.rsp1_valid, f.rsp0_valid, f.rsp_result}, {2'b01, ea});
      @(posedge clk); #2;
      chk("fp_cnt_wrap", f.ops_done, (k + 1) % 4);
    end
    f.req0_valid = 1'b0; f.req1_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
